poly_tobytes_stream: RTL and testbench

POLY_TOBYTES_STREAM -- requirements
Module: poly_tobytes_stream

---
 rtl/poly_tobytes_stream.sv | 93 +++++++++
 tb/tb_poly_tobytes_stream.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/poly_tobytes_stream.sv
// Packs eight 16-bit coefficients per beat into 12 bytes of 12-bit values.
// One output register, full-throughput valid/ready, sticky range flag.
module poly_tobytes_stream #(
    parameter int Q     = 3329,
    parameter int BEATS = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_coeffs,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [95:0]  out_bytes,
    output logic         out_last,
    output logic         range_err
);

    localparam logic [4:0]  LAST_CNT = 5'(BEATS - 1);
    localparam logic [15:0] Q16      = 16'(Q);
    localparam logic [15:0] Q2_16    = 16'(2 * Q);

    logic        vld_q, vld_d;
    logic [95:0] data_q, data_d;
    logic        last_q, last_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic [11:0] t [8];
    logic [7:0]  big;
    logic [95:0] pack;
    logic        acc;

    for (genvar k = 0; k < 8; k++) begin : g_red
        logic [15:0] c;
        logic [15:0] d;
        assign c      = in_coeffs[127-16*k -: 16];
        assign d      = c - Q16;
        assign t[k]   = (c >= Q16) ? d[11:0] : c[11:0];
        assign big[k] = (c >= Q2_16);
    end

    for (genvar p = 0; p < 4; p++) begin : g_pack
        assign pack[95-24*p -: 24] = {
            t[2*p][7:0],
            t[2*p+1][3:0], t[2*p][11:8],
            t[2*p+1][11:4]
        };
    end

    assign in_ready  = !vld_q || out_ready;
    assign acc       = in_valid && in_ready;
    assign out_valid = vld_q;
    assign out_bytes = data_q;
    assign out_last  = last_q;
    assign range_err = err_q;

    // Next state: load on input transfer, drain on bare output transfer.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        last_d = last_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        if (acc) begin
            vld_d  = 1'b1;
            data_d = pack;
            last_d = (cnt_q == LAST_CNT);
            cnt_d  = (cnt_q == LAST_CNT) ? 5'd0 : cnt_q + 5'd1;
            err_d  = err_q | (|big);
        end else if (out_ready) begin
            vld_d = 1'b0;
        end
    end

    // Output register, beat counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            last_q <= last_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_poly_tobytes_stream.sv
// Bench for poly_tobytes_stream: arithmetic model plus directed vectors.
// Model compared every falling edge; literal checks pin key scenarios.
module tb_poly_tobytes_stream;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_coeffs = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [95:0]  out_bytes;
    logic         out_last;
    logic         range_err;

    int nvec = 0;
    int nerr = 0;
    int lasttries = 0;

    poly_tobytes_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coeffs (in_coeffs),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bytes (out_bytes),
        .out_last  (out_last),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [95:0] act,
                       input logic [95:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int red(input logic [15:0] c);
        int x;
        x = int'(c);
        if (x >= 3329) x = x - 3329;
        return x % 4096;
    endfunction

    // 12-bit values laid out little-endian as a bit stream
    function automatic logic [95:0] pk(input logic [127:0] d);
        logic [95:0] r;
        int t0, t1, v;
        r = '0;
        for (int p = 0; p < 4; p++) begin
            t0 = red(d[127-32*p -: 16]);
            t1 = red(d[111-32*p -: 16]);
            v  = t0 + t1 * 4096;
            for (int b = 0; b < 3; b++)
                r[95-8*(3*p+b) -: 8] = 8'((v >> (8 * b)) & 255);
        end
        return r;
    endfunction

    function automatic bit anybig(input logic [127:0] d);
        bit r;
        r = 1'b0;
        for (int k = 0; k < 8; k++)
            if (int'(d[127-16*k -: 16]) >= 6658) r = 1'b1;
        return r;
    endfunction

    bit          mv = 1'b0;
    logic [95:0] mbytes = '0;
    bit          mlast = 1'b0;
    int          mcnt = 0;
    bit          merr = 1'b0;

    // Reference model of the stream, one register stage.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv     <= 1'b0;
            mbytes <= '0;
            mlast  <= 1'b0;
            mcnt   <= 0;
            merr   <= 1'b0;
        end else if (in_valid && (!mv || out_ready)) begin
            mv     <= 1'b1;
            mbytes <= pk(in_coeffs);
            mlast  <= (mcnt == 31);
            mcnt   <= (mcnt + 1) % 32;
            merr   <= merr | anybig(in_coeffs);
        end else if (out_ready) begin
            mv <= 1'b0;
        end
    end

    // Compare DUT against model every cycle.
    always @(negedge clk) begin
        chk("in_ready", 96'(in_ready), 96'(!mv || out_ready));
        chk("out_valid", 96'(out_valid), 96'(mv));
        chk("range_err", 96'(range_err), 96'(merr));
        if (mv) begin
            chk("out_bytes", out_bytes, mbytes);
            chk("out_last", 96'(out_last), 96'(mlast));
        end
    end

    task automatic send(input logic [127:0] d, input bit bp);
        int  tries;
        bit  ok;
        tries = 0;
        ok = 1'b0;
        in_valid  = 1'b1;
        in_coeffs = d;
        while (!ok && tries < 200) begin
            out_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            ok = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 96'(0), 96'(1));
        lasttries = tries;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_valid"}, 96'(out_valid), 96'(0));
        chk({nm, "_last"}, 96'(out_last), 96'(0));
        chk({nm, "_err"}, 96'(range_err), 96'(0));
        chk({nm, "_bytes"}, out_bytes, 96'h0);
        chk({nm, "_ready"}, 96'(in_ready), 96'(1));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("rst");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [127:0] v;

    initial begin
        chk("pin_ones", pk({8{16'h0001}}), 96'h011000011000011000011000);
        chk("pin_pair", pk({16'h0ABC, 16'h0123, 96'h0}), {24'hBC3A12, 72'h0});
        chk("pin_big", pk({16'd6658, 112'h0}), {24'h010D00, 72'h0});

        #2 chk_reset("por");
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;

        send({8{16'h0001}}, 1'b0);
        chk("ones_bytes", out_bytes, 96'h011000011000011000011000);
        chk("ones_last", 96'(out_last), 96'(0));

        send({16'h0ABC, 16'h0123, 96'h0}, 1'b0);
        chk("pair_bytes", out_bytes, {24'hBC3A12, 72'h0});

        send({16'd3329, 16'd3330, 96'h0}, 1'b0);
        chk("q_bytes", out_bytes, {24'h001000, 72'h0});
        chk("q_err", 96'(range_err), 96'(0));

        send({16'd6658, 112'h0}, 1'b0);
        chk("big_bytes", out_bytes, {24'h010D00, 72'h0});
        chk("big_err", 96'(range_err), 96'(1));
        for (int i = 0; i < 40; i++) begin
            v = {$urandom, $urandom, $urandom, $urandom} & {8{16'h0FFF}};
            send(v, 1'b0);
        end
        chk("err_sticky", 96'(range_err), 96'(1));

        do_reset();
        for (int i = 0; i < 64; i++) begin
            v = {8{16'(i * 37)}};
            send(v, 1'b0);
            chk("b2b_nogap", 96'(lasttries), 96'(1));
            chk("b2b_last", 96'(out_last), 96'((i == 31) || (i == 63)));
        end
        @(posedge clk);
        #1;

        do_reset();
        for (int i = 0; i < 17; i++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            send(v, 1'b1);
        end
        #1 rst_n = 1'b0;
        #1 chk_reset("mid");
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            v = {$urandom, $urandom, $urandom, $urandom} & {8{16'h1FFF}};
            send(v, 1'b1);
            chk("post_rst_last", 96'(out_last), 96'(i == 31));
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
